snake_draw: RTL and testbench

Cell painter that sits beside `fillscreen` in the frame pipeline. Once the frame has been cleared, it takes a stream of snake/food grid cells and plots each one as a 4x4 pixel block on the 160x120 VGA adapter. The game controller pulses `start`, then streams cells over a valid/ready handshake, marking the final cell with `cell_last`. The block drives the same `vga_x`/`vga_y`/`vga_colour`/`vga_plot` bus as `fillscreen`; the controller muxes between them.

---
 rtl/snake_draw_if.sv | 31 +++
 rtl/snake_draw.sv | 147 ++++++++++++++
 tb/tb_snake_draw.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_draw_if.sv
// Cell stream, frame control and VGA pixel bus for the snake cell painter.
// master drives cells/start; slave is the painter.
interface snake_draw_if;
   logic       start;
   logic       cell_valid;
   logic       cell_ready;
   logic [5:0] cell_x;
   logic [4:0] cell_y;
   logic [2:0] cell_colour;
   logic       cell_last;
   logic       done;
   logic       bad_cell;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   modport master (
      output start, cell_valid, cell_x, cell_y,
      output cell_colour, cell_last,
      input  cell_ready, done, bad_cell,
      input  vga_x, vga_y, vga_colour, vga_plot
   );

   modport slave (
      input  start, cell_valid, cell_x, cell_y,
      input  cell_colour, cell_last,
      output cell_ready, done, bad_cell,
      output vga_x, vga_y, vga_colour, vga_plot
   );
endinterface

// File: rtl/snake_draw.sv
// Plots 40x30 grid cells as 4x4 pixel blocks on a 160x120 VGA bus.
// Define SNAKE_DRAW_GAP_EN to plot 3x3 blocks with a one-pixel gap.
module snake_draw (
   input  logic        clk,
   input  logic        rst,
   snake_draw_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE, S_ACCEPT, S_DRAW, S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] cx_q, cx_d;
   logic [4:0] cy_q, cy_d;
   logic [2:0] col_q, col_d;
   logic       last_q, last_d;
   logic [1:0] px_q, px_d;
   logic [1:0] py_q, py_d;
   logic       done_q, done_d;
   logic       bad_q, bad_d;
   logic       plot_q, plot_d;
   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;
   logic [2:0] vcol_q, vcol_d;
   logic       legal;

   assign legal = (bus.cell_x <= 6'd39)
               && (bus.cell_y <= 5'd29);

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      col_d   = col_q;
      last_d  = last_q;
      px_d    = px_q;
      py_d    = py_q;
      done_d  = done_q;
      bad_d   = bad_q;
      x_d     = x_q;
      y_d     = y_q;
      vcol_d  = 3'd0;
      plot_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cx_d   = 6'd0;
            cy_d   = 5'd0;
            col_d  = 3'd0;
            last_d = 1'b0;
            px_d   = 2'd0;
            py_d   = 2'd0;
            done_d = 1'b0;
            if (bus.start) begin
               bad_d   = 1'b0;
               state_d = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (bus.cell_valid) begin
               cx_d   = bus.cell_x;
               cy_d   = bus.cell_y;
               col_d  = bus.cell_colour;
               last_d = bus.cell_last;
               if (legal) begin
                  state_d = S_DRAW;
                  px_d    = 2'd0;
                  py_d    = 2'd0;
                  x_d     = {bus.cell_x, 2'b00};
                  y_d     = {bus.cell_y, 2'b00};
                  vcol_d  = bus.cell_colour;
                  plot_d  = 1'b1;
               end else begin
                  bad_d = 1'b1;
                  if (bus.cell_last) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         S_DRAW: begin
            // px_q/py_q index the pixel currently on the bus
            if (px_q == 2'd3 && py_q == 2'd3) begin
               state_d = last_q ? S_DONE : S_ACCEPT;
               done_d  = last_q;
            end else begin
               px_d = px_q + 2'd1;
               if (px_q == 2'd3) py_d = py_q + 2'd1;
               x_d    = {cx_q, 2'b00} + {6'd0, px_d};
               y_d    = {cy_q, 2'b00} + {5'd0, py_d};
               vcol_d = col_q;
`ifdef SNAKE_DRAW_GAP_EN
               plot_d = (px_d != 2'd3) && (py_d != 2'd3);
`else
               plot_d = 1'b1;
`endif
            end
         end
         S_DONE: begin
            if (!bus.start) begin
               state_d = S_IDLE;
               done_d  = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cx_q    <= 6'd0;
         cy_q    <= 5'd0;
         col_q   <= 3'd0;
         last_q  <= 1'b0;
         px_q    <= 2'd0;
         py_q    <= 2'd0;
         done_q  <= 1'b0;
         bad_q   <= 1'b0;
         plot_q  <= 1'b0;
         x_q     <= 8'd0;
         y_q     <= 7'd0;
         vcol_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         col_q   <= col_d;
         last_q  <= last_d;
         px_q    <= px_d;
         py_q    <= py_d;
         done_q  <= done_d;
         bad_q   <= bad_d;
         plot_q  <= plot_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vcol_q  <= vcol_d;
      end
   end

   assign bus.cell_ready = (state_q == S_ACCEPT);
   assign bus.done       = done_q;
   assign bus.bad_cell   = bad_q;
   assign bus.vga_plot   = plot_q;
   assign bus.vga_x      = x_q;
   assign bus.vga_y      = y_q;
   assign bus.vga_colour = vcol_q;
endmodule

// File: tb/tb_snake_draw.sv
// Scoreboard bench for snake_draw: random and directed frames
// checked against a pixel-list model of each cell.
module tb_snake_draw;
   logic clk = 1'b0;
   logic rst = 1'b1;

   snake_draw_if bus ();

   snake_draw dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int col;
      bit first;
      bit fin;
   } pix_t;

   pix_t sb[$];
   int   first_cyc[$];
   int   fin_cyc[$];
   int   fx[$];
   int   fy[$];
   int   fc[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   ready_cnt = 0;
   int   plot_cnt = 0;
   int   n_pushed = 0;
   int   last_x = 0;
   int   last_y = 0;

`ifdef SNAKE_DRAW_GAP_EN
   localparam int FIN_OFF = 2;
`else
   localparam int FIN_OFF = 3;
`endif

   task automatic chk(input string nm,
                      input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
      end
   endtask

   // Reference: a legal cell is the list of its visible pixels
   task automatic push_model(input int x, input int y,
                             input int col);
      pix_t e;
      bit   on;
      int   idx;
      if (x < 40 && y < 30) begin
         for (int py = 0; py < 4; py++)
            for (int px = 0; px < 4; px++) begin
               on = 1'b1;
`ifdef SNAKE_DRAW_GAP_EN
               on = (px < 3) && (py < 3);
`endif
               if (on) begin
                  e.x     = x * 4 + px;
                  e.y     = y * 4 + py;
                  e.col   = col;
                  e.first = (px == 0 && py == 0);
                  e.fin   = 1'b0;
                  sb.push_back(e);
                  n_pushed++;
               end
            end
         idx = sb.size() - 1;
         sb[idx].fin = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      pix_t e;
      cyc++;
      if (!rst) begin
         if (bus.cell_ready) ready_cnt++;
         if (bus.vga_plot) begin
            plot_cnt++;
            if (sb.size() == 0) begin
               chk("unexpected_plot", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("vga_x", int'(bus.vga_x), e.x);
               chk("vga_y", int'(bus.vga_y), e.y);
               chk("vga_colour",
                   int'(bus.vga_colour), e.col);
               if (e.first) first_cyc.push_back(cyc);
               if (e.fin) fin_cyc.push_back(cyc);
               last_x = int'(bus.vga_x);
               last_y = int'(bus.vga_y);
            end
         end
      end
   end

   task automatic send_cell(input int x, input int y,
                            input int col, input bit last,
                            output int c, output bit ok);
      ok = 1'b0;
      c  = 0;
      bus.cell_valid  = 1'b1;
      bus.cell_x      = 6'(x);
      bus.cell_y      = 5'(y);
      bus.cell_colour = 3'(col);
      bus.cell_last   = last;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         if (bus.cell_ready) begin
            c  = cyc;
            ok = 1'b1;
            push_model(x, y, col);
            @(posedge clk);
            #1;
            break;
         end
      end
      if (!ok) chk("ready_timeout", 0, 1);
   endtask

   task automatic run_frame(input bit gaps, input bit tp);
      int xfer[$];
      int c;
      int k;
      int last_xfer;
      int dcyc;
      bit last_legal;
      bit exp_bad;
      bit ok;
      bit got;
      bit lg;
      sb.delete();
      first_cyc.delete();
      fin_cyc.delete();
      ready_cnt  = 0;
      plot_cnt   = 0;
      n_pushed   = 0;
      exp_bad    = 1'b0;
      last_xfer  = 0;
      last_legal = 1'b0;
      dcyc       = 0;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      chk("start_ready", int'(bus.cell_ready), 1);
      chk("start_bad_clr", int'(bus.bad_cell), 0);
      for (int i = 0; i < fx.size(); i++) begin
         if (gaps) begin
            bus.cell_valid = 1'b0;
            k = $urandom_range(0, 3);
            repeat (k) begin
               @(posedge clk);
               #1;
            end
         end
         send_cell(fx[i], fy[i], fc[i],
                   i == fx.size() - 1, c, ok);
         lg = (fx[i] < 40) && (fy[i] < 30);
         if (lg) xfer.push_back(c);
         else exp_bad = 1'b1;
         last_xfer  = c;
         last_legal = lg;
      end
      bus.cell_valid = 1'b0;
      got = 1'b0;
      for (int j = 0; j < 60; j++) begin
         @(negedge clk);
         #1;
         if (bus.done) begin
            got  = 1'b1;
            dcyc = cyc;
            break;
         end
      end
      if (!got) chk("done_timeout", 0, 1);
      else chk("done_lat", dcyc - last_xfer,
               last_legal ? 17 : 1);
      chk("bad_cell", int'(bus.bad_cell), int'(exp_bad));
      chk("sb_empty", sb.size(), 0);
      chk("plot_count", plot_cnt, n_pushed);
      chk("first_count", first_cyc.size(), xfer.size());
      for (int i = 0; i < first_cyc.size(); i++)
         if (i < xfer.size())
            chk("first_lat", first_cyc[i] - xfer[i], 1);
`ifndef SNAKE_DRAW_GAP_EN
      for (int i = 0; i < fin_cyc.size(); i++)
         if (i < first_cyc.size())
            chk("burst_len", fin_cyc[i] - first_cyc[i], 15);
`endif
      if (tp) begin
         for (int i = 1; i < first_cyc.size(); i++)
            chk("throughput",
                first_cyc[i] - first_cyc[i-1], 17);
         chk("ready_cycles", ready_cnt, fx.size());
      end
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("done_hold", int'(bus.done), 1);
      end
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      chk("done_drop", int'(bus.done), 0);
      chk("idle_ready", int'(bus.cell_ready), 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      bit ok;
      int n;
      bus.start       = 1'b0;
      bus.cell_valid  = 1'b0;
      bus.cell_x      = '0;
      bus.cell_y      = '0;
      bus.cell_colour = '0;
      bus.cell_last   = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", int'(bus.cell_ready), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_bad", int'(bus.bad_cell), 0);
      chk("rst_plot", int'(bus.vga_plot), 0);
      chk("rst_x", int'(bus.vga_x), 0);
      chk("rst_y", int'(bus.vga_y), 0);
      chk("rst_colour", int'(bus.vga_colour), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_no_start", int'(bus.cell_ready), 0);

      fx = '{0}; fy = '{0}; fc = '{4};
      run_frame(1'b0, 1'b0);

      fx = '{39}; fy = '{29}; fc = '{3};
      run_frame(1'b0, 1'b0);
      chk("final_x", last_x, 156 + FIN_OFF);
      chk("final_y", last_y, 116 + FIN_OFF);

      fx = '{3, 10, 39}; fy = '{4, 20, 0}; fc = '{1, 2, 7};
      run_frame(1'b0, 1'b1);

      fx = '{40, 2}; fy = '{0, 1}; fc = '{5, 6};
      run_frame(1'b0, 1'b0);

      fx = '{1}; fy = '{1}; fc = '{2};
      run_frame(1'b0, 1'b0);

      for (int f = 0; f < 15; f++) begin
         fx.delete(); fy.delete(); fc.delete();
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) begin
            fx.push_back($urandom_range(0, 44));
            fy.push_back($urandom_range(0, 31));
            fc.push_back($urandom_range(0, 7));
         end
         run_frame(1'b1, 1'b0);
      end

      // reset in the middle of drawing cell (5,5)
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      send_cell(5, 5, 2, 1'b0, c, ok);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.cell_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      chk("mrst_plot", int'(bus.vga_plot), 0);
      chk("mrst_done", int'(bus.done), 0);
      chk("mrst_ready", int'(bus.cell_ready), 0);
      chk("mrst_x", int'(bus.vga_x), 0);
      chk("mrst_colour", int'(bus.vga_colour), 0);
      @(posedge clk);
      #1;
      chk("mrst_idle", int'(bus.cell_ready), 0);
      chk("mrst_plot2", int'(bus.vga_plot), 0);

      fx = '{7}; fy = '{8}; fc = '{5};
      run_frame(1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
